// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-arbiter types: FSM states, owner indices, AXI constants.
package cpu_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_LOAD  = 1'b1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Combinational winner pick for the read arbiter.
// AXI_RD_ARB_ROUND_ROBIN_EN selects round-robin, else load has fixed priority.
module axi_rd_arb_pick
    import cpu_axi_pkg::*;
(
    input  logic       arvalid0_i,
    input  logic       arvalid1_i,
    input  logic       last_owner_i,
    output logic [1:0] win_o
);

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    always_comb begin
        win_o = 2'b00;
        if (arvalid0_i && arvalid1_i) begin
            win_o = owner_onehot(~last_owner_i);
        end else if (arvalid1_i) begin
            win_o = owner_onehot(OWNER_LOAD);
        end else if (arvalid0_i) begin
            win_o = owner_onehot(OWNER_FETCH);
        end
    end
`else
    // Load refills stall the pipeline, so they always beat fetch.
    always_comb begin
        win_o = 2'b00;
        if (arvalid1_i) begin
            win_o = owner_onehot(OWNER_LOAD);
        end else if (arvalid0_i) begin
            win_o = owner_onehot(OWNER_FETCH);
        end
    end

    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter, one burst outstanding, grant held to RLAST.
// Pick rule: AXI_RD_ARB_ROUND_ROBIN_EN for round-robin, else fixed load priority.
module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int C_M_AXI_ADDR_WIDTH      = 32,
    parameter int C_M_AXI_DATA_WIDTH      = 32,
    parameter int C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] S0_AXI_ARID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S0_AXI_ARADDR,
    input  logic [7:0]                         S0_AXI_ARLEN,
    input  logic [2:0]                         S0_AXI_ARSIZE,
    input  logic [1:0]                         S0_AXI_ARBURST,
    input  logic                               S0_AXI_ARLOCK,
    input  logic [3:0]                         S0_AXI_ARCACHE,
    input  logic [2:0]                         S0_AXI_ARPROT,
    input  logic [3:0]                         S0_AXI_ARQOS,
    input  logic [C_M_AXI_ARUSER_WIDTH-1:0]    S0_AXI_ARUSER,
    input  logic                               S0_AXI_ARVALID,
    output logic                               S0_AXI_ARREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] S0_AXI_RID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S0_AXI_RDATA,
    output logic [1:0]                         S0_AXI_RRESP,
    output logic                               S0_AXI_RLAST,
    output logic [C_M_AXI_RUSER_WIDTH-1:0]     S0_AXI_RUSER,
    output logic                               S0_AXI_RVALID,
    input  logic                               S0_AXI_RREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] S1_AXI_ARID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S1_AXI_ARADDR,
    input  logic [7:0]                         S1_AXI_ARLEN,
    input  logic [2:0]                         S1_AXI_ARSIZE,
    input  logic [1:0]                         S1_AXI_ARBURST,
    input  logic                               S1_AXI_ARLOCK,
    input  logic [3:0]                         S1_AXI_ARCACHE,
    input  logic [2:0]                         S1_AXI_ARPROT,
    input  logic [3:0]                         S1_AXI_ARQOS,
    input  logic [C_M_AXI_ARUSER_WIDTH-1:0]    S1_AXI_ARUSER,
    input  logic                               S1_AXI_ARVALID,
    output logic                               S1_AXI_ARREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] S1_AXI_RID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S1_AXI_RDATA,
    output logic [1:0]                         S1_AXI_RRESP,
    output logic                               S1_AXI_RLAST,
    output logic [C_M_AXI_RUSER_WIDTH-1:0]     S1_AXI_RUSER,
    output logic                               S1_AXI_RVALID,
    input  logic                               S1_AXI_RREADY,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY,
    output logic [1:0]                         GRANT,
    output logic                               ERR
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       err_q, err_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] win;
    logic       own_rready;

    axi_rd_arb_pick u_pick (
        .arvalid0_i   (S0_AXI_ARVALID),
        .arvalid1_i   (S1_AXI_ARVALID),
        .last_owner_i (last_owner_q),
        .win_o        (win)
    );

    // Requesters hold AR stable while valid, so the payload is a plain mux.
    assign M_AXI_ARID    = owner_q ? S1_AXI_ARID    : S0_AXI_ARID;
    assign M_AXI_ARADDR  = owner_q ? S1_AXI_ARADDR  : S0_AXI_ARADDR;
    assign M_AXI_ARLEN   = owner_q ? S1_AXI_ARLEN   : S0_AXI_ARLEN;
    assign M_AXI_ARSIZE  = owner_q ? S1_AXI_ARSIZE  : S0_AXI_ARSIZE;
    assign M_AXI_ARBURST = owner_q ? S1_AXI_ARBURST : S0_AXI_ARBURST;
    assign M_AXI_ARLOCK  = owner_q ? S1_AXI_ARLOCK  : S0_AXI_ARLOCK;
    assign M_AXI_ARCACHE = owner_q ? S1_AXI_ARCACHE : S0_AXI_ARCACHE;
    assign M_AXI_ARPROT  = owner_q ? S1_AXI_ARPROT  : S0_AXI_ARPROT;
    assign M_AXI_ARQOS   = owner_q ? S1_AXI_ARQOS   : S0_AXI_ARQOS;
    assign M_AXI_ARUSER  = owner_q ? S1_AXI_ARUSER  : S0_AXI_ARUSER;

    assign S0_AXI_RID   = M_AXI_RID;
    assign S0_AXI_RDATA = M_AXI_RDATA;
    assign S0_AXI_RRESP = M_AXI_RRESP;
    assign S0_AXI_RLAST = M_AXI_RLAST;
    assign S0_AXI_RUSER = M_AXI_RUSER;
    assign S1_AXI_RID   = M_AXI_RID;
    assign S1_AXI_RDATA = M_AXI_RDATA;
    assign S1_AXI_RRESP = M_AXI_RRESP;
    assign S1_AXI_RLAST = M_AXI_RLAST;
    assign S1_AXI_RUSER = M_AXI_RUSER;

    assign own_rready = owner_q ? S1_AXI_RREADY : S0_AXI_RREADY;
    assign GRANT = (state_q == IDLE) ? 2'b00 : owner_onehot(owner_q);
    assign ERR   = err_q;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        err_d          = err_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        M_AXI_ARVALID  = 1'b0;
        M_AXI_RREADY   = 1'b0;
        S0_AXI_ARREADY = 1'b0;
        S1_AXI_ARREADY = 1'b0;
        S0_AXI_RVALID  = 1'b0;
        S1_AXI_RVALID  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    state_d = ADDR;
                    owner_d = win[1];
                    len_d   = win[1] ? S1_AXI_ARLEN : S0_AXI_ARLEN;
                    cnt_d   = 8'd0;
                end
            end
            ADDR: begin
                M_AXI_ARVALID  = owner_q ? S1_AXI_ARVALID : S0_AXI_ARVALID;
                S0_AXI_ARREADY = !owner_q && M_AXI_ARREADY;
                S1_AXI_ARREADY = owner_q && M_AXI_ARREADY;
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                M_AXI_RREADY  = own_rready;
                S0_AXI_RVALID = !owner_q && M_AXI_RVALID;
                S1_AXI_RVALID = owner_q && M_AXI_RVALID;
                if (M_AXI_RVALID && own_rready) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // cnt_q is the index of the beat completing now.
                    if (M_AXI_RLAST) begin
                        if (cnt_q != len_q) begin
                            err_d = 1'b1;
                        end
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else if (cnt_q == len_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_FETCH;
            last_owner_q <= OWNER_LOAD;
            err_q        <= 1'b0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_q        <= err_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the core's single AXI read master port between two read requesters: requester 0 is the instruction-fetch cache refill, requester 1 is the data-load cache refill.
- Sits between the two cache read engines and the external AXI interconnect.
- Grants one requester at a time and holds the grant for the whole burst, from the AR handshake through the R beat carrying RLAST.
- Only one transaction is outstanding at any time.

Parameters:
- C_M_AXI_THREAD_ID_WIDTH, 1, ARID/RID width.
- C_M_AXI_ADDR_WIDTH, 32, ARADDR width.
- C_M_AXI_DATA_WIDTH, 32, RDATA width.
- C_M_AXI_ARUSER_WIDTH, 1, ARUSER width.
- C_M_AXI_RUSER_WIDTH, 4, RUSER width.

Ports:
- CLK  in  1  single clock; all logic is posedge.
- RST_N  in  1  asynchronous, active-low reset.
- S0_AXI_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,USER,VALID}  in  AXI widths  fetch AR request.
- S0_AXI_ARREADY  out  1  fetch AR accept.
- S0_AXI_R{ID,DATA,RESP,LAST,USER,VALID}  out  AXI widths  fetch read data.
- S0_AXI_RREADY  in  1  fetch R accept.
- S1_AXI_*  same set as S0  load requester.
- M_AXI_AR*  out (ARREADY in)  AXI widths  to interconnect.
- M_AXI_R*  in (RREADY out)  AXI widths  from interconnect.
- GRANT  out  2  one-hot current owner; 00 when idle.
- ERR  out  1  sticky burst-length protocol error.

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset (async, RST_N=0): state IDLE; GRANT=00; ERR=0; last_owner=1; beat_cnt=0.
- Reset outputs: all S*_ARREADY, S*_RVALID, M_AXI_ARVALID and M_AXI_RREADY are 0.
- Reset mid-burst: the burst is abandoned with no cleanup. The interconnect is reset on the same net.
- IDLE, no request: stays in IDLE.
- IDLE, any S*_ARVALID=1: winner chosen by the pick rule; owner registered; GRANT set; captured ARLEN latched; beat_cnt cleared; go to ADDR.
- Latency: requester ARVALID rises at cycle N -> M_AXI_ARVALID=1 at cycle N+1.
- ADDR: M_AXI_ARVALID and the AR payload are combinationally muxed from the owner.
- ADDR: owner's S_ARREADY = M_AXI_ARREADY; the non-owner's ARREADY = 0.
- ADDR: on M_AXI_ARVALID & M_AXI_ARREADY, go to DATA.
- Requesters hold the AR payload stable while ARVALID=1, per AXI. The arbiter does not re-register the payload.
- DATA: M_AXI_R* is routed to the owner; M_AXI_RREADY = owner's S_RREADY; the non-owner sees RVALID=0.
- DATA: beat_cnt increments on each R handshake.
- DATA: on a handshake with RLAST=1, go to IDLE; GRANT=00; last_owner=owner.
- The next grant decision takes at least one IDLE cycle. Back-to-back bursts therefore have a 1-cycle bubble.
- ERR is set and held until reset in either case:
  - RLAST handshake where beat_cnt != captured ARLEN;
  - beat_cnt reaching ARLEN with RLAST=0.
- beat_cnt is 8 bits and saturates at 255.
- RID is passed through and not checked. RRESP is passed through unmodified.
- A requester dropping ARVALID in ADDR violates AXI and is not required to be handled; the grant is held until handshake.
- Simultaneous requests are resolved only by the pick rule.
- A new request from the non-owner during DATA waits; its S_ARREADY stays 0.

Optional Feature:
- AXI_RD_ARB_ROUND_ROBIN_EN defined: round-robin pick.
  - When both request, the winner is the requester that is not last_owner.
  - After reset the first simultaneous request goes to S0.
- Macro undefined: fixed priority, S1 (load) always wins.
  - Stalled loads block the pipeline while fetch can be prefetched.
  - last_owner is still maintained but unused.

Decomposition:
- Shared package cpu_axi_pkg holds:
  - FSM state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2);
  - owner index constants (OWNER_FETCH=0, OWNER_LOAD=1);
  - AXI burst/resp constants (BURST_INCR=2'b01, RESP_OKAY=2'b00).
- One natural sub-module, axi_rd_arb_pick: combinational; inputs are the two ARVALIDs and last_owner; output is the one-hot winner. It contains the macro-selected pick rule.

Test Plan:
- Single fetch request: S0 ARADDR=0x2000_0000, ARLEN=3. Required: GRANT=01 the cycle after ARVALID; M_AXI_ARADDR=0x2000_0000; 4 beats reach S0 only; GRANT=00 after the RLAST beat; ERR=0.
- Simultaneous S0 and S1 requests, macro off. Required: S1 granted first, S0 granted after S1's RLAST plus 1 IDLE cycle. With macro: S0 first, then S1.
- Round-robin fairness, macro on: both requesters held asserted for 4 bursts. Required: grant sequence S0, S1, S0, S1.
- M_AXI_ARREADY held low 5 cycles, then M_AXI_RVALID stalled. Required: ARVALID and payload stable throughout; S1 request waits with S1_ARREADY=0; no beat is leaked to the non-owner.
- Length error: ARLEN=3 but RLAST on beat 2. Required: ERR=1 the cycle after; state returns to IDLE; ERR stays 1 across later good bursts.
- RST_N pulsed low mid-DATA. Required: GRANT=00, M_AXI_RREADY=0 and ERR=0 immediately without a clock edge; a fresh request after release is served normally.
